// File: rtl/mbox_mem_arb.sv
// EBOX / front-end arbiter and sequencer in front of the MBOX backing memory.
// Define MBOX_MEM_ARB_RR_EN for a round-robin tie-break; otherwise EBOX always wins a tie.
module mbox_mem_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 36,
  parameter int RD_LAT = 1
) (
  input  logic              mboxClk,
  input  logic              RESET,
  input  logic              eboxReq,
  input  logic              eboxWrite,
  input  logic [ADDR_W-1:0] eboxAddr,
  input  logic [DATA_W-1:0] eboxDataW,
  output logic [DATA_W-1:0] eboxDataR,
  output logic              eboxAck,
  input  logic              feReq,
  input  logic              feWrite,
  input  logic [ADDR_W-1:0] feAddr,
  input  logic [DATA_W-1:0] feDataW,
  output logic [DATA_W-1:0] feDataR,
  output logic              feAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  input  logic [DATA_W-1:0] memDout,
  output logic              memWe,
  output logic              busy
);

  // state     | meaning
  // ST_IDLE   | no transaction; a winner is latched on the way out
  // ST_ACCESS | latched address/data on the memory bus, memWe for writes
  // ST_WAIT   | RD_LAT cycles of read latency, memDout captured on the last one
  // ST_RESP   | one-cycle ack to the granted requester
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       gnt_fe;
  logic       op_wr;
  logic       grant;
  logic       capture;
  logic       pick_fe;

`ifdef MBOX_MEM_ARB_RR_EN
  logic last_fe;

  always_ff @(posedge mboxClk) begin
    if (RESET) last_fe <= 1'b1;
    else if (grant) last_fe <= pick_fe;
  end

  // On a tie the requester that did not win last time goes next.
  assign pick_fe = feReq && (!eboxReq || !last_fe);
`else
  assign pick_fe = feReq && !eboxReq;
`endif

  always_ff @(posedge mboxClk) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    capture   = 1'b0;
    memWe     = 1'b0;
    busy      = (state != ST_IDLE);
    eboxAck   = 1'b0;
    feAck     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (eboxReq || feReq) begin
          grant     = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        memWe = op_wr;
        if (op_wr) begin
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt   = LAT_LOAD;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt <= 3'd1) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ST_RESP: begin
        eboxAck   = !gnt_fe;
        feAck     = gnt_fe;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // memAddr/memDin are the latched request, so they hold until the next grant.
  always_ff @(posedge mboxClk) begin
    if (RESET) begin
      gnt_fe    <= 1'b0;
      op_wr     <= 1'b0;
      memAddr   <= '0;
      memDin    <= '0;
      eboxDataR <= '0;
      feDataR   <= '0;
    end else begin
      if (grant) begin
        gnt_fe  <= pick_fe;
        op_wr   <= pick_fe ? feWrite   : eboxWrite;
        memAddr <= pick_fe ? feAddr    : eboxAddr;
        memDin  <= pick_fe ? feDataW   : eboxDataW;
      end
      if (capture) begin
        if (gnt_fe) feDataR   <= memDout;
        else        eboxDataR <= memDout;
      end
    end
  end

endmodule

// File: tb/tb_mbox_mem_arb.sv
// Self-checking bench for mbox_mem_arb: directed table, corner sequences, random traffic
// against a transaction-level reference model. Honours MBOX_MEM_ARB_RR_EN.
module tb_mbox_mem_arb;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 36;
  localparam int RD_LAT = 3;
  localparam int M_NONE = 0;
  localparam int M_RAND = 1;
  localparam int M_WR   = 2;

  logic              mboxClk = 1'b0;
  logic              RESET;
  logic              eboxReq, eboxWrite, eboxAck;
  logic [ADDR_W-1:0] eboxAddr;
  logic [DATA_W-1:0] eboxDataW, eboxDataR;
  logic              feReq, feWrite, feAck;
  logic [ADDR_W-1:0] feAddr;
  logic [DATA_W-1:0] feDataW, feDataR;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDin, memDout;
  logic              memWe, busy;

  always #5 mboxClk = ~mboxClk;

  mbox_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .mboxClk(mboxClk), .RESET(RESET),
    .eboxReq(eboxReq), .eboxWrite(eboxWrite), .eboxAddr(eboxAddr),
    .eboxDataW(eboxDataW), .eboxDataR(eboxDataR), .eboxAck(eboxAck),
    .feReq(feReq), .feWrite(feWrite), .feAddr(feAddr),
    .feDataW(feDataW), .feDataR(feDataR), .feAck(feAck),
    .memAddr(memAddr), .memDin(memDin), .memDout(memDout),
    .memWe(memWe), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
    if (a == 12'o0000) return 36'o111111111111;
    if (a == 12'o0001) return 36'o777777000000;
    return {a, 12'o5252, a};
  endfunction

  // Backing memory: synchronous write, RD_LAT-deep read pipeline.
  logic [DATA_W-1:0] mem [4096];
  bit                written [4096];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge mboxClk) begin
    if (memWe) begin
      mem[memAddr]     <= memDin;
      written[memAddr] <= 1'b1;
    end
    rd_pipe[0] <= written[memAddr] ? mem[memAddr] : preload(memAddr);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign memDout = rd_pipe[RD_LAT-1];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one transaction record plus the first cycle the arbiter is free.
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] exp_dr [2];
  bit                tv;
  int                t_who, t_g, t_ack, free_at;
  bit                t_wr;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_data;
`ifdef MBOX_MEM_ARB_RR_EN
  int                last_who;
`endif

  // Requester agents.
  bit                pend [2];
  bit                granted [2];
  bit                rw [2];
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rdat [2];
  int                ack_cyc [2];
  int                ack_who_q [$];
  int                ack_cyc_q [$];

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return preload(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge mboxClk);
    cyc++;
  endtask

  task automatic drive();
    eboxReq = pend[0]; eboxWrite = rw[0]; eboxAddr = ra[0]; eboxDataW = rdat[0];
    feReq   = pend[1]; feWrite   = rw[1]; feAddr   = ra[1]; feDataW   = rdat[1];
  endtask

  task automatic engine(input int mode);
    bit have;
    int w;
    have = tv && cyc > t_g && cyc <= t_ack;
    if (have && cyc == t_g + 1 && t_wr) ref_mem[int'(t_addr)] = t_data;
    if (have && cyc == t_ack && !t_wr) exp_dr[t_who] = ref_rd(t_addr);
    chk("busy",      busy,      have);
    chk("memWe",     memWe,     have && cyc == t_g + 1 && t_wr);
    chk("eboxAck",   eboxAck,   have && cyc == t_ack && t_who == 0);
    chk("feAck",     feAck,     have && cyc == t_ack && t_who == 1);
    chk("eboxDataR", eboxDataR, exp_dr[0]);
    chk("feDataR",   feDataR,   exp_dr[1]);
    if (tv && cyc > t_g) chk("memAddr", memAddr, t_addr);
    if (have && cyc == t_g + 1 && t_wr) chk("memDin", memDin, t_data);
    if (have && cyc == t_ack) begin
      pend[t_who]    = 1'b0;
      granted[t_who] = 1'b0;
      ack_cyc[t_who] = cyc;
      ack_who_q.push_back(t_who);
      ack_cyc_q.push_back(cyc);
    end
    for (int r = 0; r < 2; r++) begin
      if (!pend[r]) begin
        if (mode == M_RAND && $urandom_range(0, 2) != 0) begin
          pend[r] = 1'b1;
          rw[r]   = 1'($urandom_range(0, 1));
          ra[r]   = 12'(16 + $urandom_range(0, 7));
          rdat[r] = {4'($urandom), $urandom};
        end else if (mode == M_WR) begin
          pend[r] = 1'b1;
          rw[r]   = 1'b1;
          ra[r]   = 12'(32 + r);
          rdat[r] = {4'($urandom), $urandom};
        end
      end else if (granted[r] && mode == M_RAND) begin
        rw[r]   = 1'($urandom_range(0, 1));
        ra[r]   = 12'($urandom);
        rdat[r] = {4'($urandom), $urandom};
      end
    end
    drive();
    if (cyc >= free_at && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) begin
`ifdef MBOX_MEM_ARB_RR_EN
        w = (last_who == 0) ? 1 : 0;
`else
        w = 0;
`endif
      end else begin
        w = pend[1] ? 1 : 0;
      end
`ifdef MBOX_MEM_ARB_RR_EN
      last_who = w;
`endif
      tv         = 1'b1;
      t_who      = w;
      t_g        = cyc;
      t_wr       = rw[w];
      t_addr     = ra[w];
      t_data     = rdat[w];
      t_ack      = cyc + 2 + (rw[w] ? 0 : RD_LAT);
      free_at    = t_ack + 1;
      granted[w] = 1'b1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; granted[r] = 1'b0;
    end
    drive();
    tick();
    RESET     = 1'b0;
    tv        = 1'b0;
    free_at   = cyc;
    exp_dr[0] = '0;
    exp_dr[1] = '0;
`ifdef MBOX_MEM_ARB_RR_EN
    last_who  = 1;
`endif
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memDin",  memDin,  0);
    engine(M_NONE);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (!pend[0] && !pend[1] && cyc >= free_at) break;
      tick();
      engine(M_NONE);
    end
    chk("drain_idle", {pend[0], pend[1]}, 0);
  endtask

  task automatic apply(input int who, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, output int lat);
    int t0;
    tick();
    pend[who] = 1'b1; rw[who] = wr; ra[who] = a; rdat[who] = d;
    t0 = cyc;
    engine(M_NONE);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      engine(M_NONE);
      if (!pend[who]) begin
        lat = ack_cyc[who] - t0;
        break;
      end
    end
  endtask

  typedef struct {
    int                who;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                lat;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  vec_t              tbl [10];
  logic [DATA_W-1:0] last_rd [2];
  logic [DATA_W-1:0] dr;
  int                lat, t0, exp_w;
  bit                rereq;

  initial begin
    tbl[0] = '{0, 1'b1, 12'o0100, 36'o123456701234, 2,          36'o0};
    tbl[1] = '{0, 1'b0, 12'o0100, 36'o0,            2 + RD_LAT, 36'o123456701234};
    tbl[2] = '{1, 1'b1, 12'o7777, 36'o000000777777, 2,          36'o0};
    tbl[3] = '{1, 1'b0, 12'o7777, 36'o0,            2 + RD_LAT, 36'o000000777777};
    tbl[4] = '{1, 1'b0, 12'o0000, 36'o0,            2 + RD_LAT, 36'o111111111111};
    tbl[5] = '{1, 1'b0, 12'o0001, 36'o0,            2 + RD_LAT, 36'o777777000000};
    tbl[6] = '{0, 1'b1, 12'o0000, 36'o525252525252, 2,          36'o0};
    tbl[7] = '{1, 1'b0, 12'o0000, 36'o0,            2 + RD_LAT, 36'o525252525252};
    tbl[8] = '{0, 1'b0, 12'o7777, 36'o0,            2 + RD_LAT, 36'o000000777777};
    tbl[9] = '{0, 1'b1, 12'o0100, 36'o0,            2,          36'o0};

    for (int r = 0; r < 2; r++) begin
      rw[r] = 1'b0; ra[r] = '0; rdat[r] = '0; ack_cyc[r] = 0; last_rd[r] = '0;
    end
    t_who = 0; t_g = 0; t_ack = 0; t_wr = 1'b0; t_addr = '0; t_data = '0;
    do_reset();

    // Directed single transactions from idle.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].who, tbl[i].wr, tbl[i].addr, tbl[i].data, lat);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      dr = (tbl[i].who == 0) ? eboxDataR : feDataR;
      if (!tbl[i].wr) begin
        chk($sformatf("tbl%0d_rdata", i), dr, tbl[i].rdata);
        last_rd[tbl[i].who] = tbl[i].rdata;
      end else begin
        chk($sformatf("tbl%0d_hold", i), dr, last_rd[tbl[i].who]);
      end
    end

    // Simultaneous reads; EBOX re-requests the moment it is acked.
    do_reset();
    ack_who_q.delete(); ack_cyc_q.delete();
    tick();
    pend[0] = 1'b1; rw[0] = 1'b0; ra[0] = 12'o0100;
    pend[1] = 1'b1; rw[1] = 1'b0; ra[1] = 12'o0001;
    t0 = cyc;
    engine(M_NONE);
    rereq = 1'b0;
    for (int i = 0; i < 60 && ack_who_q.size() < 3; i++) begin
      tick();
      engine(M_NONE);
      if (!rereq && ack_who_q.size() == 1) begin
        rereq = 1'b1;
        pend[0] = 1'b1; rw[0] = 1'b0; ra[0] = 12'o7777;
        drive();
      end
    end
    chk("tie_nacks", ack_who_q.size(), 3);
    if (ack_who_q.size() == 3) begin
      chk("tie_first_who", ack_who_q[0], 0);
      chk("tie_first_lat", ack_cyc_q[0] - t0, 2 + RD_LAT);
`ifdef MBOX_MEM_ARB_RR_EN
      chk("tie_second_who", ack_who_q[1], 1);
      chk("tie_third_who",  ack_who_q[2], 0);
`else
      chk("tie_second_who", ack_who_q[1], 0);
      chk("tie_third_who",  ack_who_q[2], 1);
`endif
      chk("tie_gap1", ack_cyc_q[1] - ack_cyc_q[0], 3 + RD_LAT);
      chk("tie_gap2", ack_cyc_q[2] - ack_cyc_q[1], 3 + RD_LAT);
    end
    drain();

    // Both requesters issue writes back to back.
    do_reset();
    ack_who_q.delete(); ack_cyc_q.delete();
    for (int i = 0; i < 100 && ack_who_q.size() < 8; i++) begin
      tick();
      engine(M_WR);
    end
    chk("wr_nacks", ack_who_q.size(), 8);
    for (int i = 0; i < ack_who_q.size() && i < 8; i++) begin
`ifdef MBOX_MEM_ARB_RR_EN
      exp_w = i % 2;
`else
      exp_w = 0;
`endif
      chk($sformatf("wr%0d_who", i), ack_who_q[i], exp_w);
      if (i > 0) chk($sformatf("wr%0d_gap", i), ack_cyc_q[i] - ack_cyc_q[i-1], 3);
    end
    drain();

    // Reset during the WAIT of an EBOX read: no ack, data regs cleared.
    do_reset();
    apply(0, 1'b1, 12'o0200, 36'o246135724613, lat);
    tick();
    pend[0] = 1'b1; rw[0] = 1'b0; ra[0] = 12'o0200;
    t0 = cyc;
    engine(M_NONE);
    while (cyc < t0 + 3) begin
      tick();
      engine(M_NONE);
    end
    do_reset();
    chk("rst_wait_busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      engine(M_NONE);
    end
    apply(0, 1'b0, 12'o0200, 36'o0, lat);
    chk("rst_wait_relat", lat, 2 + RD_LAT);
    chk("rst_wait_rdata", eboxDataR, 36'o246135724613);

    // Reset right after the ACCESS cycle of a write: the write stays in memory.
    tick();
    pend[1] = 1'b1; rw[1] = 1'b1; ra[1] = 12'o0300; rdat[1] = 36'o135702461357;
    t0 = cyc;
    engine(M_NONE);
    tick();
    engine(M_NONE);
    do_reset();
    apply(1, 1'b0, 12'o0300, 36'o0, lat);
    chk("rst_acc_rdata", feDataR, 36'o135702461357);

    // Random traffic, fields scrambled after grant.
    for (int i = 0; i < 600; i++) begin
      tick();
      engine(M_RAND);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog @cyc %0d: got timeout, want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
